// File: rtl/sys_regbank_pkg.sv
// Shared word map, STATUS/CTRL bit positions and bus FSM encoding for the
// system register bank.
package sys_regbank_pkg;

  localparam int W_ID        = 0;
  localparam int W_STATUS    = 1;
  localparam int W_CTRL      = 2;
  localparam int W_FIFO_DATA = 3;
  localparam int REGIN_BASE  = 16;
  localparam int REGOUT_BASE = 32;

  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  localparam logic [31:0] ID_DEFAULT = 32'h5253_0002;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1,
    S_WAIT = 2'd2
  } bus_state_e;

endpackage

// File: rtl/sys_sync_fifo.sv
// Synchronous capture FIFO with flush, sticky overflow and push-while-full
// accepted only when a pop frees the slot in the same cycle.
module sys_sync_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic          clr_ovf_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          do_pop, do_push, drop;

  assign full_o  = (count_q == DEPTH);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // A push swallowed by a flush is discarded, not counted as an overflow.
  assign drop    = push_i & full_o & ~do_pop & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
      if (drop)           ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/sys_regbank.sv
// Wishbone classic register bank: ID/STATUS/CTRL, capture FIFO drain port,
// synchronised status inputs and byte-writable control outputs.
module sys_regbank
  import sys_regbank_pkg::*;
#(
  parameter int          N_IN     = 8,
  parameter int          N_OUT    = 8,
  parameter int          FIFO_AW  = 4,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  input  logic [32*N_IN-1:0]    regin,
  output logic [32*N_OUT-1:0]   regout,
  input  logic [31:0]           fifo_wr_in,
  input  logic                  fifo_wr_en,
  output logic [1:0]            dbg_state_o
);

  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  bus_state_e           state_q;
  logic                 ack_q, err_q;
  logic [31:0]          dat_q;
  logic [32*N_IN-1:0]   sync1_q, sync2_q;
  logic [32*N_OUT-1:0]  regout_q, regout_d;
  logic [5:0]           word_idx;
  logic                 access, rd_ok, wr_ok, hit_ok;
  logic                 pop_hit, flush_hit, clr_hit;
  logic [N_OUT-1:0]     out_hit;
  logic [31:0]          rd_data, status_w, fifo_head;
  logic [FIFO_AW:0]     fifo_count;
  logic                 fifo_full, fifo_empty, fifo_ovf;
  logic                 unused_adr;

  assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Handshake: a transfer is requested while cyc&stb are high in IDLE; it is
  // terminated by exactly one ack or err cycle, and the next request is taken
  // only after the master has dropped stb.
  assign word_idx = wb_adr_i[7:2];
  assign access   = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i;

  always_comb begin
    status_w = '0;
    status_w[FIFO_AW:0] = fifo_count;
    status_w[ST_EMPTY]  = fifo_empty;
    status_w[ST_FULL]   = fifo_full;
    status_w[ST_OVF]    = fifo_ovf;
  end

  always_comb begin
    rd_ok = 1'b0; wr_ok = 1'b0; rd_data = '0;
    pop_hit = 1'b0; flush_hit = 1'b0; clr_hit = 1'b0; out_hit = '0;
    if (int'(word_idx) == W_ID) begin
      rd_ok = 1'b1; rd_data = ID_VALUE;
    end else if (int'(word_idx) == W_STATUS) begin
      rd_ok = 1'b1; rd_data = status_w;
    end else if (int'(word_idx) == W_CTRL) begin
      rd_ok = 1'b1; wr_ok = 1'b1;
      flush_hit = wb_sel_i[0] & wb_dat_i[CTRL_FLUSH];
      clr_hit   = wb_sel_i[0] & wb_dat_i[CTRL_CLR_OVF];
    end else if (int'(word_idx) == W_FIFO_DATA) begin
      rd_ok = 1'b1; pop_hit = ~fifo_empty;
      rd_data = fifo_empty ? 32'h0 : fifo_head;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (int'(word_idx) == REGIN_BASE + k) begin
          rd_ok = 1'b1; rd_data = sync2_q[32*k +: 32];
        end
      end
      for (int k = 0; k < N_OUT; k++) begin
        if (int'(word_idx) == REGOUT_BASE + k) begin
          rd_ok = 1'b1; wr_ok = 1'b1; out_hit[k] = 1'b1;
          rd_data = regout_q[32*k +: 32];
        end
      end
    end
  end

  assign hit_ok = wb_we_i ? wr_ok : rd_ok;

  always_comb begin
    regout_d = regout_q;
    for (int k = 0; k < N_OUT; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (access && wb_we_i && out_hit[k] && wb_sel_i[b])
          regout_d[32*k+8*b +: 8] = wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      regout_q <= '0;
    end else begin
      sync1_q  <= regin;
      sync2_q  <= sync1_q;
      regout_q <= regout_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (access) begin
          state_q <= S_RESP;
          ack_q   <= hit_ok;
          err_q   <= ~hit_ok;
          dat_q   <= (wb_we_i || !hit_ok) ? 32'h0 : rd_data;
        end
        S_RESP: begin
          state_q <= S_WAIT;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          dat_q   <= '0;
        end
        S_WAIT:  if (!(wb_cyc_i && wb_stb_i)) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sys_sync_fifo #(.DW(32), .AW(FIFO_AW)) u_fifo (
    .clk_i     (wb_clk_i),
    .rst_ni    (rst_n),
    .push_i    (fifo_wr_en),
    .pop_i     (access & ~wb_we_i & pop_hit),
    .flush_i   (access & wb_we_i & flush_hit),
    .clr_ovf_i (access & wb_we_i & clr_hit),
    .data_i    (fifo_wr_in),
    .data_o    (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ovf_o     (fifo_ovf)
  );

  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_dat_o    = dat_q;
  assign regout      = regout_q;
  assign dbg_state_o = state_q;

endmodule
